// File: rtl/stream_in_source_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : stream_src_pkg
//  Description : Shared types and defaults for the stream_in_source block.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_src_pkg;

    // Sequencer states of the stream transmitter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } src_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 8;
    localparam int GAP_W_DEFAULT  = 4;
    localparam int CNT_W_DEFAULT  = 16;

endpackage : stream_src_pkg
`default_nettype wire

// File: rtl/stream_in_source_if.sv
`default_nettype none
// ============================================================================
//  Interface   : stream_in_source_if
//  Description : Load handshake, stream handshake and control/status signals
//                of stream_in_source. slave = the block, master = its user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_in_source_if
    import stream_src_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int GAP_W  = GAP_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) ();

    localparam int ADDR_W = $clog2(DEPTH);

    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              enable;
    logic [GAP_W-1:0]  gap_cycles;
    logic              stream_in_valid;
    logic              stream_in_ready;
    logic [DATA_W-1:0] stream_in_data;
    logic [ADDR_W:0]   level;
    logic [CNT_W-1:0]  sent_count;

    modport master (
        output load_valid, load_data, enable, gap_cycles, stream_in_ready,
        input  load_ready, stream_in_valid, stream_in_data, level, sent_count
    );

    modport slave (
        input  load_valid, load_data, enable, gap_cycles, stream_in_ready,
        output load_ready, stream_in_valid, stream_in_data, level, sent_count
    );

endinterface : stream_in_source_if
`default_nettype wire

// File: rtl/stream_in_source_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : stream_fifo
//  Description : Register-array FIFO with wrap-bit pointers. Head word is
//                read straight from the array; the consumer registers it.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
    import stream_src_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  wire                        clk,
    input  wire                        rst,
    input  wire                        wr_en_i,
    input  wire  [DATA_W-1:0]          wr_data_i,
    input  wire                        rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int              ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_ptr_one = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q;
    logic [ADDR_W:0]   rd_ptr_q;
    logic              w_wr;
    logic              w_rd;

    // Overflow/underflow requests are ignored rather than corrupting pointers
    assign w_wr = wr_en_i && !full_o;
    assign w_rd = rd_en_i && !empty_o;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Pointer update; reset discards all queued contents
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + c_ptr_one;
            if (w_rd) rd_ptr_q <= rd_ptr_q + c_ptr_one;
        end
    end

    // Storage write; contents need no reset because pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end

endmodule : stream_fifo
`default_nettype wire

// File: rtl/stream_in_source.sv
`default_nettype none
// ============================================================================
//  Module      : stream_in_source
//  Description : Replays bytes loaded into a FIFO onto a valid/ready stream,
//                honouring backpressure and a programmable inter-word gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_in_source
    import stream_src_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int GAP_W  = GAP_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  wire               clk,
    input  wire               rst,
    stream_in_source_if.slave bus
);

    localparam int              ADDR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] c_gap_one = {{(GAP_W-1){1'b0}}, 1'b1};

    src_state_t        state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  sent_q,  sent_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;

    logic              w_fetch;
    logic              w_can_fetch;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic [ADDR_W:0]   w_level;

    stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.load_valid && bus.load_ready),
        .wr_data_i (bus.load_data),
        .rd_en_i   (w_fetch),
        .rd_data_o (w_head),
        .full_o    (w_full),
        .empty_o   (w_empty),
        .level_o   (w_level)
    );

    // Ready follows the registered full flag only, so a same-cycle pop never
    // opens a slot early
    assign bus.load_ready      = !rst && !w_full;
    assign bus.stream_in_valid = (state_q == SEND);
    assign bus.stream_in_data  = data_q;
    assign bus.level           = w_level;
    assign bus.sent_count      = sent_q;

    assign w_can_fetch = !w_empty && bus.enable;

    // Sequencer state, output word, gap counter and handshake counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state: launch words, hold under backpressure, time the idle gap
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        w_fetch = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_can_fetch) begin
                    w_fetch = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.stream_in_ready) begin
                    sent_d = sent_q + c_cnt_one;
                    gap_d  = bus.gap_cycles;
                    if (bus.gap_cycles != '0) begin
                        state_d = GAP;
                    end else if (w_can_fetch) begin
                        w_fetch = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - c_gap_one;
                // Last gap cycle: the next word appears right after this edge
                if (gap_q <= c_gap_one) begin
                    if (w_can_fetch) begin
                        w_fetch = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_fetch) data_d = w_head;
    end

endmodule : stream_in_source
`default_nettype wire
